// File: rtl/apb_reg_pkg.sv
// ============================================================================
// Module   : apb_reg_pkg
// Brief    : Shared transfer-state encoding and wait-state limits for the APB
//            register bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int c_max_wait_cycles = 15;
    localparam int c_wait_cnt_w      = $clog2(c_max_wait_cycles + 1);

endpackage

`default_nettype wire

// File: rtl/apb_reg_wait_ctrl.sv
// ============================================================================
// Module   : apb_reg_wait_ctrl
// Brief    : APB transfer sequencer: setup detection, wait-state counter and
//            registered pready, with strobes for the register bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_reg_wait_ctrl
    import apb_reg_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic pclk,
    input  logic presetn,
    input  logic psel,
    input  logic penable,
    output logic setup,
    output logic to_done,
    output logic done,
    output logic pready
);

    state_t                  r_state;
    logic [c_wait_cnt_w-1:0] r_cnt;
    logic                    r_pready;

    assign setup = (r_state == ST_IDLE) && psel && !penable;

    // Asserted on the edge that enters DONE; the bank samples read data here.
    assign to_done = (setup && (WAIT_CYCLES == 0)) ||
                     ((r_state == ST_WAIT) && psel && (r_cnt == '0));

    assign done   = (r_state == ST_DONE) && psel && penable;
    assign pready = r_pready;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_pready <= 1'b0;
        end else begin
            r_pready <= to_done;
            case (r_state)
                ST_IDLE: begin
                    if (setup) begin
                        if (WAIT_CYCLES == 0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= c_wait_cnt_w'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!psel) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_reg_bank.sv
// ============================================================================
// Module   : apb_reg_bank
// Brief    : APB slave register bank with byte strobes, read-only masking,
//            hardware-side writes and per-register write pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_reg_bank
    import apb_reg_pkg::*;
#(
    parameter int                  ADDR_WIDTH  = 8,
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  NUM_REGS    = 16,
    parameter int                  WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                           pclk,
    input  logic                           presetn,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS-1:0]            hw_we,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int c_idx_w  = ADDR_WIDTH - 2;
    localparam int c_nbytes = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_nbytes-1:0]   r_strb;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_wr_pulse;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                  r_pslverr;

    logic                  w_setup;
    logic                  w_to_done;
    logic                  w_done;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_wr;
    logic [c_idx_w-1:0]    w_idx;
    logic                  w_legal;
    logic                  w_ro;
    logic [DATA_WIDTH-1:0] w_rd;
    logic                  w_bus_we;
    logic [NUM_REGS-1:0]   w_hit;

    apb_reg_wait_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_ctrl (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .setup   (w_setup),
        .to_done (w_to_done),
        .done    (w_done),
        .pready  (pready)
    );

    // With zero wait states DONE is entered on the setup edge itself, so the
    // decode must look at the live bus instead of the captured copy.
    assign w_addr  = w_setup ? paddr : r_addr;
    assign w_wr    = w_setup ? pwrite : r_write;
    assign w_idx   = w_addr[ADDR_WIDTH-1:2];
    assign w_legal = (w_addr[1:0] == 2'b00) && (int'(w_idx) < NUM_REGS);

    always_comb begin
        w_rd = '0;
        w_ro = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == c_idx_w'(i)) begin
                w_rd = r_regs[i];
                w_ro = RO_MASK[i];
            end
        end
    end

    assign w_bus_we = w_done && r_write && w_legal && !w_ro;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_hit[i] = w_bus_we && (w_idx == c_idx_w'(i));
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            if (w_setup) begin
                r_addr  <= paddr;
                r_write <= pwrite;
                r_wdata <= pwdata;
                r_strb  <= pstrb;
            end
            if (w_to_done) begin
                r_prdata  <= (w_legal && !w_wr) ? w_rd : '0;
                r_pslverr <= !w_legal || (w_wr && w_ro);
            end else begin
                r_prdata  <= '0;
                r_pslverr <= 1'b0;
            end
        end
    end

    // Bus commit takes priority over the hardware port on the same register.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_hit[i]) begin
                    for (int b = 0; b < c_nbytes; b++) begin
                        if (r_strb[b]) begin
                            r_regs[i][b*8 +: 8] <= r_wdata[b*8 +: 8];
                        end
                    end
                end else if (hw_we[i]) begin
                    r_regs[i] <= hw_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            r_wr_pulse <= w_hit;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
    end

    assign prdata   = r_prdata;
    assign pslverr  = r_pslverr;
    assign wr_pulse = r_wr_pulse;

endmodule

`default_nettype wire

// File: doc/apb_reg_bank.md
APB_REG_BANK -- requirements
Module: apb_reg_bank

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: APB address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32: data width in bits; legal values 8, 16, 32, 64.
REQ-003 Parameter NUM_REGS, default 16: register count; legal range 1..2^(ADDR_WIDTH-2).
REQ-004 Parameter WAIT_CYCLES, default 0: wait states inserted before pready; legal range 0..15.
REQ-005 Parameter RO_MASK, default all zeros, NUM_REGS bits: bit i=1 makes register i bus-read-only.
REQ-006 Clock and reset are fixed: one clock; reset is synchronous and active-low.
REQ-007 pclk  in  1  clock; every flop rises on pclk.
REQ-008 presetn  in  1  synchronous active-low reset.
REQ-009 paddr  in  ADDR_WIDTH  byte address.
REQ-010 psel, penable, pwrite  in  1 each  APB controls.
REQ-011 pwdata  in  DATA_WIDTH  write data.
REQ-012 pstrb  in  DATA_WIDTH/8  byte write strobes.
REQ-013 prdata  out  DATA_WIDTH  read data.
REQ-014 pready, pslverr  out  1 each  transfer-complete and error flags.
REQ-015 reg_q  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i occupies slice i.
REQ-016 hw_we  in  NUM_REGS  hardware-side write enable for each register.
REQ-017 hw_wdata  in  NUM_REGS*DATA_WIDTH  hardware-side write data.
REQ-018 wr_pulse  out  NUM_REGS  one-cycle pulse after each successful bus write.

Function
REQ-019 Decode: index = paddr[ADDR_WIDTH-1:2]; an access is illegal when index >= NUM_REGS or paddr[1:0] != 0.
REQ-020 FSM states: IDLE, WAIT, DONE.
REQ-021 IDLE transitions: on psel=1 and penable=0, capture paddr, pwrite, pwdata and pstrb; go to DONE if WAIT_CYCLES=0, otherwise go to WAIT with the counter loaded to WAIT_CYCLES-1.
REQ-022 WAIT behaviour: the counter decrements each cycle; when the counter is 0, go to DONE.
REQ-023 DONE behaviour: pready=1 for exactly one cycle; return to IDLE unconditionally.
REQ-024 Latency: pready is seen in access cycle 1+WAIT_CYCLES counted from setup, so WAIT_CYCLES=0 gives zero-wait APB timing.
REQ-025 pready, prdata and pslverr shall be registered; prdata=0 and pslverr=0 whenever pready=0.
REQ-026 Write commit: on the DONE edge with psel=1 and penable=1 for a legal, non-RO write, update each byte b with pstrb[b]=1; all other bytes are unchanged.
REQ-027 pstrb=0 is legal: no bytes change, no error, and wr_pulse still fires.
REQ-028 Writes to a register whose RO_MASK bit is 1 shall set pslverr=1 and leave the register unchanged.
REQ-029 Illegal addresses shall set pslverr=1; a write has no effect and a read returns prdata=0.
REQ-030 Read: prdata equals the register value sampled on the edge that enters DONE.
REQ-031 wr_pulse[i]=1 in the cycle after a committed write to register i, and 0 otherwise.
REQ-032 Hardware write: hw_we[i]=1 loads hw_wdata slice i on the next edge, for RO and RW registers alike.
REQ-033 Collision: when a bus commit and hw_we hit the same register on the same edge, the bus wins and the hw write is dropped.
REQ-034 Abort: if psel=0 in WAIT or DONE, return to IDLE, drop pready, and commit nothing.
REQ-035 Back-to-back transfers: a setup cycle immediately after DONE shall be accepted with no idle cycle.

Reset
REQ-036 With presetn=0 at a pclk edge: state=IDLE, counter=0, all registers=0, prdata=0, pready=0, pslverr=0, wr_pulse=0.
REQ-037 Reset asserted mid-transfer aborts the transfer with no commit.
REQ-038 Reset dominates hw_we.

Structure
REQ-039 Shared package apb_reg_pkg holds the state enum and the WAIT_CYCLES legal maximum.
REQ-040 One sub-module, apb_reg_wait_ctrl, holds the FSM and wait counter and outputs a done strobe; storage and decode stay in the top module.
REQ-041 Estimated size is 150-250 lines of RTL.

Verification
REQ-042 Byte write with WAIT_CYCLES=0: write 0xDEADBEEF to 0x04 with pstrb=0xF, then read 0x04 -> pready in the first access cycle, prdata=0xDEADBEEF, pslverr=0, wr_pulse[1] pulses once.
REQ-043 Partial strobe: register 2=0x11223344, write 0xAABBCCDD with pstrb=0x5 -> reads back 0x11BB33DD.
REQ-044 Wait states with WAIT_CYCLES=3: read 0x00 -> pready high only in access cycle 4; pready stays 0 and no commit occurs if psel drops in access cycle 2.
REQ-045 Errors with NUM_REGS=16: write to 0x40 -> pslverr=1 and no register changes; write to 0x06 -> pslverr=1; write to RO register 3 -> pslverr=1 and the value is unchanged.
REQ-046 Collision: on register 5, bus commit 0x1 on the same edge as hw_we[5]=1 with 0x2 -> register reads 0x1; on the next idle edge, hw write 0x2 -> register reads 0x2.
REQ-047 Reset mid-WAIT: presetn=0 for one edge -> all outputs and reg_q read 0; the next transfer completes normally.
